// File: rtl/multiport_regfile.sv
// ---------------------------------------------------------------------------
// multiport_regfile
//
// Purpose:
//   A register file with NRD read ports and two write ports. Register 0 is
//   hard-wired to zero. After reset, a clear sweep writes zero to registers
//   1..NREGS-1, one register per cycle. While the sweep runs, busy is high,
//   every read port returns zero and all writes are dropped.
//
// Configuration:
//   REGFILE_BYPASS_EN - when defined, a read whose address matches an
//                       enabled nonzero write in the same cycle returns the
//                       write data combinationally (write port 1 wins).
//                       When undefined, such a read returns the old contents
//                       and the new value appears after the clock edge.
//
// Parameters:
//   XLEN   - register data width in bits
//   ADDR_W - register address width (NREGS = 2**ADDR_W)
//   NRD    - number of read ports (1..4)
//
// Ports:
//   clk            - clock; all state changes on its rising edge
//   rst            - synchronous active-high reset; restarts the clear sweep
//   RS             - read addresses, port k at [k*ADDR_W +: ADDR_W]
//   Rd             - read data, port k at [k*XLEN +: XLEN] (combinational)
//   RD0, RD1       - write addresses for write ports 0 and 1
//   write_enable0/1- write strobes
//   Write_data0/1  - write data
//   busy           - high while the clear sweep runs
// ---------------------------------------------------------------------------
module multiport_regfile #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*ADDR_W-1:0] RS,
    output logic [NRD*XLEN-1:0]   Rd,
    input  logic [ADDR_W-1:0]     RD0,
    input  logic [ADDR_W-1:0]     RD1,
    input  logic                  write_enable0,
    input  logic                  write_enable1,
    input  logic [XLEN-1:0]       Write_data0,
    input  logic [XLEN-1:0]       Write_data1,
    output logic                  busy
);

    localparam int NREGS = 1 << ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [ADDR_W-1:0]   cnt_reg;
    logic [ADDR_W-1:0]   cnt_next;

    logic [XLEN-1:0]     mem [NREGS];

    logic                ready;
    logic                wr0_en;
    logic                wr1_en;

    // -----------------------------------------------------------------------
    // Sweep FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= CLEAR;
            cnt_reg   <= ADDR_W'(1);
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // -----------------------------------------------------------------------
    // Sweep FSM: next state. The counter starts at 1 because register 0 is
    // never stored, so the sweep takes NREGS-1 cycles.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (state_reg == CLEAR) begin
            cnt_next = cnt_reg + ADDR_W'(1);
            if (cnt_reg == '1) begin
                state_next = READY;
                cnt_next   = ADDR_W'(1);
            end
        end
    end

    assign ready = (state_reg == READY);
    assign busy  = (state_reg == CLEAR);

    // -----------------------------------------------------------------------
    // Write qualification. Port 0 is suppressed when port 1 targets the same
    // address in the same cycle so the port 1 data is the one that lands.
    // -----------------------------------------------------------------------
    assign wr1_en = ready && !rst && write_enable1 && (RD1 != '0);
    assign wr0_en = ready && !rst && write_enable0 && (RD0 != '0) &&
                    !(wr1_en && (RD1 == RD0));

    // -----------------------------------------------------------------------
    // Storage. While rst is held, only register 1 is re-zeroed (the sweep
    // is pinned at its first entry); everything else is left alone.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[1] <= '0;
        end else if (state_reg == CLEAR) begin
            mem[cnt_reg] <= '0;
        end else begin
            if (wr0_en) begin
                mem[RD0] <= Write_data0;
            end
            if (wr1_en) begin
                mem[RD1] <= Write_data1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read ports: combinational. Zero is forced for address 0, while the
    // sweep runs, and while rst is asserted, which also masks contents that
    // were never initialised.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            logic [ADDR_W-1:0] rd_addr;
            logic [XLEN-1:0]   rd_data;

            assign rd_addr = RS[gi*ADDR_W +: ADDR_W];

            always_comb begin
                rd_data = mem[rd_addr];
`ifdef REGFILE_BYPASS_EN
                // wr*_en already exclude address 0, busy and rst.
                if (wr1_en && (RD1 == rd_addr)) begin
                    rd_data = Write_data1;
                end else if (wr0_en && (RD0 == rd_addr)) begin
                    rd_data = Write_data0;
                end
`endif
                if (!ready || rst || (rd_addr == '0)) begin
                    rd_data = '0;
                end
            end

            assign Rd[gi*XLEN +: XLEN] = rd_data;
        end
    endgenerate

endmodule
